// File: rtl/split_access_seq_pkg.sv
// rtl/split_access_seq_pkg.sv - shared memory-subsystem constants and sequencer state encoding
package split_access_seq_pkg;

    localparam int LINE_W_DEF = 128;
    localparam int PADR_W_DEF = 15;
    localparam int SHIFT_W    = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P0_REQ  = 3'd1,
        P0_WAIT = 3'd2,
        P1_REQ  = 3'd3,
        P1_WAIT = 3'd4,
        RESP    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/split_access_seq_byte_funnel_shr.sv
// rtl/split_access_seq_byte_funnel_shr.sv - byte-granular funnel shifter, 2*W in, low W out
module byte_funnel_shr
    import split_access_seq_pkg::*;
#(
    parameter int W = LINE_W_DEF
) (
    input  logic [2*W-1:0]     din,
    input  logic [SHIFT_W-1:0] shift,
    output logic [W-1:0]       dout
);

    always_comb begin
        dout = W'(din >> {shift, 3'b000});
    end

endmodule

// File: rtl/split_access_seq.sv
// rtl/split_access_seq.sv - sequences one or two cache-line accesses and merges read data (option: SPLIT_ACCESS_CNT_EN)
module split_access_seq
    import split_access_seq_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int PADR_W = PADR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PADR_W-1:0]  req_addr0,
    input  logic [PADR_W-1:0]  req_addr1,
    input  logic               req_need_p1,
    input  logic               req_wr,
    input  logic [LINE_W-1:0]  req_mask0,
    input  logic [LINE_W-1:0]  req_mask1,
    input  logic [LINE_W-1:0]  req_data0,
    input  logic [LINE_W-1:0]  req_data1,
    input  logic [SHIFT_W-1:0] req_shift,
    output logic               c_valid,
    input  logic               c_ready,
    output logic [PADR_W-1:0]  c_addr,
    output logic               c_wr,
    output logic [LINE_W-1:0]  c_mask,
    output logic [LINE_W-1:0]  c_wdata,
    input  logic               c_rvalid,
    input  logic [LINE_W-1:0]  c_rdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [LINE_W-1:0]  rsp_data
`ifdef SPLIT_ACCESS_CNT_EN
    ,
    output logic [CNT_W-1:0]   split_cnt
`endif
);

    seq_state_e         state, state_nxt;
    logic               started;
    logic               accept;
    logic [PADR_W-1:0]  addr0_q, addr1_q;
    logic               need_p1_q, wr_q;
    logic [LINE_W-1:0]  mask0_q, mask1_q, data0_q, data1_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [LINE_W-1:0]  line0_q, line1_q;
    logic [LINE_W-1:0]  merged;
    logic               in_p0, in_p1;

    // started keeps req_ready low until the first edge after reset release
    assign accept = req_valid && req_ready;
    assign in_p0  = (state == P0_REQ);
    assign in_p1  = (state == P1_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            started   <= 1'b0;
            addr0_q   <= '0;
            addr1_q   <= '0;
            need_p1_q <= 1'b0;
            wr_q      <= 1'b0;
            mask0_q   <= '0;
            mask1_q   <= '0;
            data0_q   <= '0;
            data1_q   <= '0;
            shift_q   <= '0;
            line0_q   <= '0;
            line1_q   <= '0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (accept) begin
                addr0_q   <= req_addr0;
                addr1_q   <= req_addr1;
                need_p1_q <= req_need_p1;
                wr_q      <= req_wr;
                mask0_q   <= req_mask0;
                mask1_q   <= req_mask1;
                data0_q   <= req_data0;
                data1_q   <= req_data1;
                shift_q   <= req_shift;
            end
            if (state == P0_WAIT && c_rvalid) begin
                line0_q <= c_rdata;
            end
            if (state == P1_WAIT && c_rvalid) begin
                line1_q <= c_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = P0_REQ;
            P0_REQ:  if (c_ready)   state_nxt = P0_WAIT;
            P0_WAIT: if (c_rvalid)  state_nxt = need_p1_q ? P1_REQ : RESP;
            P1_REQ:  if (c_ready)   state_nxt = P1_WAIT;
            P1_WAIT: if (c_rvalid)  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // A stale line1 from an earlier split must not leak into an unsplit read
    byte_funnel_shr #(
        .W (LINE_W)
    ) u_funnel (
        .din   ({need_p1_q ? line1_q : {LINE_W{1'b0}}, line0_q}),
        .shift (shift_q),
        .dout  (merged)
    );

    always_comb begin
        req_ready = started && (state == IDLE);
        c_valid   = in_p0 || in_p1;
        c_wr      = c_valid && wr_q;
        c_addr    = '0;
        c_mask    = '0;
        c_wdata   = '0;
        if (in_p0) begin
            c_addr  = addr0_q;
            c_mask  = mask0_q;
            c_wdata = data0_q;
        end else if (in_p1) begin
            c_addr  = addr1_q;
            c_mask  = mask1_q;
            c_wdata = data1_q;
        end
        rsp_valid = (state == RESP);
        rsp_data  = (rsp_valid && !wr_q) ? merged : '0;
    end

`ifdef SPLIT_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_cnt <= '0;
        end else if (accept && req_need_p1 && (split_cnt != {CNT_W{1'b1}})) begin
            split_cnt <= split_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_split_access_seq.sv
// tb/tb_split_access_seq.sv - directed and random checks of split_access_seq against a byte-level model
module tb_split_access_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [14:0]  req_addr0, req_addr1;
    logic         req_need_p1, req_wr;
    logic [127:0] req_mask0, req_mask1, req_data0, req_data1;
    logic [3:0]   req_shift;
    logic         c_valid, c_ready, c_wr, c_rvalid;
    logic [14:0]  c_addr;
    logic [127:0] c_mask, c_wdata, c_rdata;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_data;
`ifdef SPLIT_ACCESS_CNT_EN
    logic [15:0]  split_cnt;
`endif

    int passed = 0;
    int total  = 0;
    logic [127:0] mem [logic [14:0]];

    always #5 clk = ~clk;

    split_access_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_need_p1(req_need_p1), .req_wr(req_wr),
        .req_mask0(req_mask0), .req_mask1(req_mask1),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_shift(req_shift),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wr(c_wr),
        .c_mask(c_mask), .c_wdata(c_wdata),
        .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
`ifdef SPLIT_ACCESS_CNT_EN
        , .split_cnt(split_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] seq_line(input int start);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = 8'(start + i);
        return l;
    endfunction

    function automatic logic [127:0] line_of(input logic [14:0] a);
        if (!mem.exists(a)) mem[a] = rnd128();
        return mem[a];
    endfunction

    // Expected merged read: bytes shift..shift+15 of the two-line byte stream
    function automatic logic [127:0] model_read(input logic [127:0] l0, input logic [127:0] l1,
                                                input logic np1, input logic [3:0] sh);
        logic [7:0] b [32];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            b[i]      = l0[8*i +: 8];
            b[16 + i] = np1 ? l1[8*i +: 8] : 8'h00;
        end
        for (int j = 0; j < 16; j++) r[8*j +: 8] = b[int'(sh) + j];
        return r;
    endfunction

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_c_valid"}, c_valid, 0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_c_addr"}, c_addr, 0);
        chk({pfx, "_c_mask"}, c_mask, 0);
        chk({pfx, "_c_wdata"}, c_wdata, 0);
        chk({pfx, "_c_wr"}, c_wr, 0);
        chk({pfx, "_rsp_data"}, rsp_data, 0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic run_access(input string tag, input logic [14:0] a0, input logic [14:0] a1,
                              input logic np1, input logic wr,
                              input logic [127:0] m0, input logic [127:0] m1,
                              input logic [127:0] d0, input logic [127:0] d1,
                              input logic [3:0] sh, input int stall, input int rwait,
                              input logic stray, input logic [127:0] exp_fixed, input logic use_fixed);
        logic [127:0] exp_rsp, rv_data;
        logic rv_pend;
        int cyc, ntx, stalls, holds;
        bit done;
        if (wr) exp_rsp = '0;
        else exp_rsp = model_read(line_of(a0), np1 ? line_of(a1) : 128'h0, np1, sh);
        if (use_fixed) chk({tag, "_model_const"}, exp_rsp, exp_fixed);
        chk({tag, "_req_ready_idle"}, req_ready, 1);
        req_valid = 1; req_addr0 = a0; req_addr1 = a1; req_need_p1 = np1; req_wr = wr;
        req_mask0 = m0; req_mask1 = m1; req_data0 = d0; req_data1 = d1; req_shift = sh;
        @(negedge clk);
        req_valid = 0; req_addr0 = '1; req_data0 = rnd128(); req_shift = 4'(~sh);
        cyc = 1; ntx = 0; stalls = 0; holds = 0; done = 0; rv_pend = 0; rv_data = '0;
        while (!done && cyc < 100) begin
            c_rvalid = rv_pend;
            c_rdata  = rv_pend ? rv_data : rnd128();
            rv_pend  = 0;
            c_ready  = 0;
            rsp_ready = 0;
            if (c_valid) begin
                chk({tag, "_c_addr"}, c_addr, (ntx == 0) ? a0 : a1);
                chk({tag, "_c_mask"}, c_mask, (ntx == 0) ? m0 : m1);
                chk({tag, "_c_wdata"}, c_wdata, (ntx == 0) ? d0 : d1);
                chk({tag, "_c_wr"}, c_wr, wr);
                chk({tag, "_req_ready_busy"}, req_ready, 0);
                if (ntx == 0 && stalls < stall) begin
                    stalls++;
                end else begin
                    c_ready = 1;
                    rv_pend = 1;
                    rv_data = wr ? rnd128() : line_of((ntx == 0) ? a0 : a1);
                    ntx++;
                    if (stray) begin
                        c_rvalid = 1;
                        c_rdata  = rnd128();
                    end
                end
            end
            if (rsp_valid) begin
                if (holds == 0) begin
                    chk({tag, "_latency"}, 128'(cyc), 128'(3 + (np1 ? 2 : 0) + stall));
                    chk({tag, "_num_tx"}, 128'(ntx), np1 ? 2 : 1);
                end
                chk({tag, "_rsp_data"}, rsp_data, exp_rsp);
                if (holds < rwait) holds++;
                else begin
                    rsp_ready = 1;
                    done = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        c_rvalid = 0; c_ready = 0; rsp_ready = 0;
        chk({tag, "_completed"}, 128'(done), 1);
        chk({tag, "_rsp_drop"}, rsp_valid, 0);
    endtask

    initial begin
        logic [14:0]  a;
        logic [127:0] m0, m1;
        rst_n = 0; req_valid = 0; req_addr0 = 0; req_addr1 = 0; req_need_p1 = 0; req_wr = 0;
        req_mask0 = 0; req_mask1 = 0; req_data0 = 0; req_data1 = 0; req_shift = 0;
        c_ready = 0; c_rvalid = 0; c_rdata = 0; rsp_ready = 0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        check_idle_outputs("reset");
        rst_n = 1;
        @(negedge clk);
        chk("post_reset_req_ready", req_ready, 1);

        // unsplit read, byte i of the line holds i
        mem[15'h0120] = seq_line(0);
        run_access("rd_unsplit", 15'h0120, 15'h0121, 0, 0, '1, '0, '0, '0, 4'd4, 0, 0, 0,
                   128'h000000000F0E0D0C0B0A090807060504, 1);

        // split read across two lines
        mem[15'h0200] = seq_line(8'h00);
        mem[15'h0201] = seq_line(8'h10);
        run_access("rd_split", 15'h0200, 15'h0201, 1, 0, '1, '1, '0, '0, 4'd14, 0, 2, 1,
                   128'h1D1C1B1A191817161514131211100F0E, 1);

        // split write: both halves go out with their own mask and data
        run_access("wr_split", 15'h0333, 15'h0334, 1, 1,
                   128'hFFFF0000_00000000_00000000_00000000, 128'h00000000_00000000_00000000_0000FFFF,
                   rnd128(), rnd128(), 4'd14, 0, 1, 0, '0, 1);

        // c_ready withheld for five cycles in the first request phase
        run_access("rd_stall", 15'h0444, 15'h0445, 0, 0, rnd128(), '0, rnd128(), '0,
                   4'd0, 5, 0, 0, '0, 0);

        for (int k = 0; k < 24; k++) begin
            a  = 15'($urandom);
            m0 = rnd128();
            m1 = rnd128();
            run_access("rand", a, a + 15'd1, 1'($urandom), 1'($urandom), m0, m1, rnd128(), rnd128(),
                       4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       1'($urandom), '0, 0);
        end

        // reset while waiting on the second line, with a stray completion
        req_valid = 1; req_addr0 = 15'h0055; req_addr1 = 15'h0056; req_need_p1 = 1; req_wr = 0;
        req_shift = 4'd3;
        @(negedge clk);
        req_valid = 0; c_ready = 1;
        @(negedge clk);
        c_ready = 0; c_rvalid = 1; c_rdata = rnd128();
        @(negedge clk);
        c_rvalid = 0; c_ready = 1;
        chk("rst_p1_req_addr", c_addr, 15'h0056);
        @(negedge clk);
        c_ready = 0;
        rst_n = 0;
        #1;
        chk("rst_mid_req_ready", req_ready, 0);
        check_idle_outputs("rst_mid");
        c_rvalid = 1; c_rdata = rnd128();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        c_rvalid = 0;
        chk("rst_after_req_ready", req_ready, 1);
        check_idle_outputs("rst_after");
        @(negedge clk);
        chk("rst_later_rsp_valid", rsp_valid, 0);

        run_access("post_rst_split", 15'h0600, 15'h0601, 1, 0, '1, '1, '0, '0, 4'd9, 1, 0, 0, '0, 0);
`ifdef SPLIT_ACCESS_CNT_EN
        chk("split_cnt", split_cnt, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
